// File: rtl/axil_wb_pkg.sv
// Shared types and constants for the AXI4-Lite to Wishbone bridge.
package axil_wb_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WB_WR,
    ST_WB_RD,
    ST_B_RESP,
    ST_R_RESP
  } axil_wb_state_e;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  // Byte-lane count for a given data width.
  function automatic int unsigned strb_width(input int unsigned data_width);
    return data_width / 8;
  endfunction

endpackage

// File: rtl/wb_timeout_ctr.sv
// Counts cycles spent waiting on a Wishbone slave and flags the last allowed one.
module wb_timeout_ctr #(
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr,
  input  logic en,
  output logic expired
);

  if (TIMEOUT_CYCLES == 0) begin : g_off
    logic unused_inputs;
    assign unused_inputs = ^{clk_i, rst_i, clr, en};
    assign expired = 1'b0;
  end else begin : g_on
    localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

    logic [CW-1:0] count;

    // Cycle counter, cleared on termination or while idle.
    always_ff @(posedge clk_i) begin
      if (rst_i || clr) begin
        count <= '0;
      end else if (en) begin
        count <= count + CW'(1);
      end
    end

    assign expired = en && (count == LAST);
  end

endmodule

// File: rtl/axil_wb_bridge_gen.sv
// AXI4-Lite slave to Wishbone B4 classic master, one transaction in flight,
// round-robin read/write arbitration, err/timeout mapped to SLVERR.
module axil_wb_bridge_gen
  import axil_wb_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH     = 32,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned TIMEOUT_CYCLES = 256,
  localparam int unsigned STRB_WIDTH    = strb_width(DATA_WIDTH)
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [ADDR_WIDTH-1:0] s_awaddr_i,
  input  logic                  s_awvalid_i,
  output logic                  s_awready_o,
  input  logic [DATA_WIDTH-1:0] s_wdata_i,
  input  logic [STRB_WIDTH-1:0] s_wstrb_i,
  input  logic                  s_wvalid_i,
  output logic                  s_wready_o,
  output logic [1:0]            s_bresp_o,
  output logic                  s_bvalid_o,
  input  logic                  s_bready_i,
  input  logic [ADDR_WIDTH-1:0] s_araddr_i,
  input  logic                  s_arvalid_i,
  output logic                  s_arready_o,
  output logic [DATA_WIDTH-1:0] s_rdata_o,
  output logic [1:0]            s_rresp_o,
  output logic                  s_rvalid_o,
  input  logic                  s_rready_i,
  output logic [ADDR_WIDTH-1:0] wb_adr_o,
  output logic [DATA_WIDTH-1:0] wb_dat_o,
  output logic [STRB_WIDTH-1:0] wb_sel_o,
  output logic                  wb_we_o,
  output logic                  wb_cyc_o,
  output logic                  wb_stb_o,
  input  logic [DATA_WIDTH-1:0] wb_dat_i,
  input  logic                  wb_ack_i,
  input  logic                  wb_err_i
);

  axil_wb_state_e state_q, state_d;
  logic last_was_read;
  logic grant_wr, grant_rd, done, fail, in_wb, expired;
  logic wr_pend, rd_pend;

  assign wr_pend = s_awvalid_i && s_wvalid_i;
  assign rd_pend = s_arvalid_i;
  assign in_wb   = (state_q == ST_WB_WR) || (state_q == ST_WB_RD);

  wb_timeout_ctr #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .clr    (done || !in_wb),
    .en     (in_wb),
    .expired(expired)
  );

  // State register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state, arbitration and termination decode.
  always_comb begin
    state_d  = state_q;
    grant_wr = 1'b0;
    grant_rd = 1'b0;
    done     = 1'b0;
    fail     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!rst_i) begin
          if (wr_pend && (!rd_pend || last_was_read)) begin
            grant_wr = 1'b1;
            state_d  = ST_WB_WR;
          end else if (rd_pend) begin
            grant_rd = 1'b1;
            state_d  = ST_WB_RD;
          end
        end
      end
      ST_WB_WR, ST_WB_RD: begin
        if (wb_ack_i || wb_err_i || expired) begin
          done    = 1'b1;
          fail    = wb_err_i || !wb_ack_i;
          state_d = (state_q == ST_WB_WR) ? ST_B_RESP : ST_R_RESP;
        end
      end
      ST_B_RESP: begin
        if (s_bready_i) state_d = ST_IDLE;
      end
      ST_R_RESP: begin
        if (s_rready_i) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Request capture, response capture and arbitration history.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wb_adr_o      <= '0;
      wb_dat_o      <= '0;
      wb_sel_o      <= '0;
      s_bresp_o     <= RESP_OKAY;
      s_rresp_o     <= RESP_OKAY;
      s_rdata_o     <= '0;
      last_was_read <= 1'b1;
    end else begin
      if (grant_wr) begin
        wb_adr_o <= s_awaddr_i;
        wb_dat_o <= s_wdata_i;
        wb_sel_o <= s_wstrb_i;
      end
      if (grant_rd) begin
        wb_adr_o <= s_araddr_i;
        wb_sel_o <= '1;
      end
      if (done && (state_q == ST_WB_WR)) begin
        s_bresp_o <= fail ? RESP_SLVERR : RESP_OKAY;
      end
      if (done && (state_q == ST_WB_RD)) begin
        s_rresp_o <= fail ? RESP_SLVERR : RESP_OKAY;
        s_rdata_o <= fail ? '0 : wb_dat_i;
      end
      if ((state_q == ST_B_RESP) && s_bready_i) last_was_read <= 1'b0;
      if ((state_q == ST_R_RESP) && s_rready_i) last_was_read <= 1'b1;
    end
  end

  assign s_awready_o = grant_wr;
  assign s_wready_o  = grant_wr;
  assign s_arready_o = grant_rd;
  assign wb_cyc_o    = in_wb;
  assign wb_stb_o    = in_wb;
  assign wb_we_o     = (state_q == ST_WB_WR);
  assign s_bvalid_o  = (state_q == ST_B_RESP);
  assign s_rvalid_o  = (state_q == ST_R_RESP);

endmodule

// File: tb/tb_axil_wb_bridge_gen.sv
// Bench for axil_wb_bridge_gen: bench-driven Wishbone memory slave plus a
// word-array reference model of what AXI should observe.
module tb_axil_wb_bridge_gen;

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned SW = 4;
  localparam int unsigned TO = 16;

  localparam int M_ACK  = 0;
  localparam int M_ERR  = 1;
  localparam int M_NONE = 2;
  localparam int M_BOTH = 3;

  logic          clk = 1'b0;
  logic          rst_i = 1'b1;
  logic [AW-1:0] s_awaddr_i = '0;
  logic          s_awvalid_i = 1'b0;
  logic          s_awready_o;
  logic [DW-1:0] s_wdata_i = '0;
  logic [SW-1:0] s_wstrb_i = '0;
  logic          s_wvalid_i = 1'b0;
  logic          s_wready_o;
  logic [1:0]    s_bresp_o;
  logic          s_bvalid_o;
  logic          s_bready_i = 1'b0;
  logic [AW-1:0] s_araddr_i = '0;
  logic          s_arvalid_i = 1'b0;
  logic          s_arready_o;
  logic [DW-1:0] s_rdata_o;
  logic [1:0]    s_rresp_o;
  logic          s_rvalid_o;
  logic          s_rready_i = 1'b0;
  logic [AW-1:0] wb_adr_o;
  logic [DW-1:0] wb_dat_o;
  logic [SW-1:0] wb_sel_o;
  logic          wb_we_o;
  logic          wb_cyc_o;
  logic          wb_stb_o;
  logic [DW-1:0] wb_dat_i = '0;
  logic          wb_ack_i = 1'b0;
  logic          wb_err_i = 1'b0;

  int total = 0;
  int bad = 0;

  logic [31:0] smem [16];
  logic [31:0] mdl  [16];

  always #5 clk = ~clk;

  axil_wb_bridge_gen #(
    .ADDR_WIDTH(AW),
    .DATA_WIDTH(DW),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk_i(clk), .rst_i(rst_i),
    .s_awaddr_i(s_awaddr_i), .s_awvalid_i(s_awvalid_i), .s_awready_o(s_awready_o),
    .s_wdata_i(s_wdata_i), .s_wstrb_i(s_wstrb_i), .s_wvalid_i(s_wvalid_i),
    .s_wready_o(s_wready_o), .s_bresp_o(s_bresp_o), .s_bvalid_o(s_bvalid_o),
    .s_bready_i(s_bready_i), .s_araddr_i(s_araddr_i), .s_arvalid_i(s_arvalid_i),
    .s_arready_o(s_arready_o), .s_rdata_o(s_rdata_o), .s_rresp_o(s_rresp_o),
    .s_rvalid_o(s_rvalid_o), .s_rready_i(s_rready_i),
    .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o), .wb_sel_o(wb_sel_o), .wb_we_o(wb_we_o),
    .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_dat_i(wb_dat_i),
    .wb_ack_i(wb_ack_i), .wb_err_i(wb_err_i)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Present one AXI request and check it is granted in the same cycle.
  task automatic issue(input bit is_rd, input logic [31:0] addr,
                       input logic [31:0] data, input logic [3:0] strb);
    @(negedge clk);
    if (is_rd) begin
      s_araddr_i = addr; s_arvalid_i = 1'b1;
    end else begin
      s_awaddr_i = addr; s_wdata_i = data; s_wstrb_i = strb;
      s_awvalid_i = 1'b1; s_wvalid_i = 1'b1;
    end
    #1;
    chk("ready_grant", 64'(is_rd ? s_arready_o : (s_awready_o & s_wready_o)), 64'(1));
    @(posedge clk);
    #1;
    s_awvalid_i = 1'b0; s_wvalid_i = 1'b0; s_arvalid_i = 1'b0;
  endtask

  // Wishbone memory slave: responds wt cycles after cyc rises according to mode.
  task automatic wb_serve(input int mode, input int wt, output int n,
                          output logic [31:0] s_adr, output logic s_we,
                          output logic [3:0] s_sel, output logic [31:0] s_dat);
    int idx;
    n = 0; s_adr = '0; s_we = 1'b0; s_sel = '0; s_dat = '0;
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      wb_ack_i = 1'b0; wb_err_i = 1'b0; wb_dat_i = $urandom;
      if (!wb_cyc_o) break;
      n++;
      if (n == 1) begin
        s_adr = wb_adr_o; s_we = wb_we_o; s_sel = wb_sel_o; s_dat = wb_dat_o;
      end
      if (n == wt + 1) begin
        if (mode == M_ACK || mode == M_BOTH) wb_ack_i = 1'b1;
        if (mode == M_ERR || mode == M_BOTH) wb_err_i = 1'b1;
        if (mode == M_ACK) begin
          idx = int'(wb_adr_o[5:2]);
          if (wb_we_o) begin
            for (int b = 0; b < 4; b++)
              if (wb_sel_o[b]) smem[idx][8*b +: 8] = wb_dat_o[8*b +: 8];
          end else begin
            wb_dat_i = smem[idx];
          end
        end
      end
    end
  endtask

  // Check the held response, optionally stall the master, then handshake.
  task automatic resp_wait(input bit is_rd, input int hold,
                           input logic [1:0] exp_resp, input logic [31:0] exp_data);
    for (int h = 0; h <= hold; h++) begin
      if (h > 0) @(negedge clk);
      if (is_rd) begin
        chk("rvalid_held", 64'(s_rvalid_o), 64'(1));
        chk("rresp", 64'(s_rresp_o), 64'(exp_resp));
        chk("rdata", 64'(s_rdata_o), 64'(exp_data));
      end else begin
        chk("bvalid_held", 64'(s_bvalid_o), 64'(1));
        chk("bresp", 64'(s_bresp_o), 64'(exp_resp));
      end
    end
    if (is_rd) s_rready_i = 1'b1; else s_bready_i = 1'b1;
    @(posedge clk);
    #1;
    s_rready_i = 1'b0; s_bready_i = 1'b0;
    chk("valid_drop", 64'(is_rd ? s_rvalid_o : s_bvalid_o), 64'(0));
  endtask

  // Full transaction with expectations derived from the reference model.
  task automatic do_txn(input bit is_rd, input int idx, input logic [31:0] data,
                        input logic [3:0] strb, input int mode, input int wt, input int hold);
    logic [31:0] addr, exp_data, s_adr, s_dat;
    logic [1:0]  exp_resp;
    logic [3:0]  s_sel;
    logic        s_we;
    int          n, exp_n;
    addr     = 32'(idx) << 2;
    exp_resp = (mode == M_ACK) ? 2'b00 : 2'b10;
    exp_n    = (mode == M_NONE) ? int'(TO) : wt + 1;
    exp_data = (is_rd && mode == M_ACK) ? mdl[idx] : 32'h0;
    issue(is_rd, addr, data, strb);
    wb_serve(mode, wt, n, s_adr, s_we, s_sel, s_dat);
    chk("cyc_len", 64'(n), 64'(exp_n));
    chk("wb_adr", 64'(s_adr), 64'(addr));
    chk("wb_we", 64'(s_we), 64'(!is_rd));
    chk("wb_sel", 64'(s_sel), 64'(is_rd ? 4'hF : strb));
    if (!is_rd) chk("wb_dat", 64'(s_dat), 64'(data));
    if (!is_rd && mode == M_ACK)
      for (int b = 0; b < 4; b++)
        if (strb[b]) mdl[idx][8*b +: 8] = data[8*b +: 8];
    resp_wait(is_rd, hold, exp_resp, exp_data);
  endtask

  task automatic do_reset();
    rst_i = 1'b1;
    s_awvalid_i = 1'b0; s_wvalid_i = 1'b0; s_arvalid_i = 1'b0;
    s_bready_i = 1'b0; s_rready_i = 1'b0; wb_ack_i = 1'b0; wb_err_i = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_i = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] s_adr, s_dat, wd;
    logic [3:0]  s_sel;
    logic        s_we;
    int          n;

    for (int i = 0; i < 16; i++) begin
      smem[i] = 32'h0; mdl[i] = 32'h0;
    end
    smem[8] = 32'hDEADBEEF; mdl[8] = 32'hDEADBEEF;

    // Reset values
    do_reset();
    #1;
    chk("rst_cyc", 64'(wb_cyc_o), 64'(0));
    chk("rst_stb", 64'(wb_stb_o), 64'(0));
    chk("rst_we", 64'(wb_we_o), 64'(0));
    chk("rst_sel", 64'(wb_sel_o), 64'(0));
    chk("rst_adr", 64'(wb_adr_o), 64'(0));
    chk("rst_bvalid", 64'(s_bvalid_o), 64'(0));
    chk("rst_rvalid", 64'(s_rvalid_o), 64'(0));
    chk("rst_rdata", 64'(s_rdata_o), 64'(0));
    chk("rst_readies", 64'({s_awready_o, s_wready_o, s_arready_o}), 64'(0));

    // Zero-wait write, then read with 3 wait cycles
    do_txn(1'b0, 4, 32'hCAFEF00D, 4'hF, M_ACK, 0, 0);
    do_txn(1'b1, 8, 32'h0, 4'h0, M_ACK, 3, 1);
    do_txn(1'b1, 4, 32'h0, 4'h0, M_ACK, 0, 0);

    // Error responses, ack+err together, timeout, recovery
    do_txn(1'b0, 5, 32'h12345678, 4'hF, M_ERR, 1, 0);
    do_txn(1'b1, 8, 32'h0, 4'h0, M_ERR, 2, 0);
    do_txn(1'b1, 8, 32'h0, 4'h0, M_BOTH, 0, 0);
    do_txn(1'b1, 8, 32'h0, 4'h0, M_NONE, 0, 0);
    do_txn(1'b1, 8, 32'h0, 4'h0, M_ACK, 0, 0);

    // Late ack outside a cycle is ignored
    @(negedge clk);
    wb_ack_i = 1'b1;
    @(negedge clk);
    wb_ack_i = 1'b0;
    chk("late_ack_b", 64'({s_bvalid_o, s_rvalid_o, wb_cyc_o}), 64'(0));

    // Simultaneous AW/W/AR after reset: write first, read blocked by B backpressure
    do_reset();
    wd = $urandom;
    @(negedge clk);
    s_awaddr_i = 32'h8; s_wdata_i = wd; s_wstrb_i = 4'hF;
    s_awvalid_i = 1'b1; s_wvalid_i = 1'b1;
    s_araddr_i = 32'h8; s_arvalid_i = 1'b1;
    #1;
    chk("rr_aw_first", 64'({s_awready_o, s_wready_o, s_arready_o}), 64'(3'b110));
    @(posedge clk);
    #1;
    s_awvalid_i = 1'b0; s_wvalid_i = 1'b0;
    wb_serve(M_ACK, 0, n, s_adr, s_we, s_sel, s_dat);
    mdl[2] = wd;
    chk("rr_wr_len", 64'(n), 64'(1));
    chk("rr_wr_we", 64'(s_we), 64'(1));
    for (int h = 0; h < 5; h++) begin
      chk("rr_bvalid", 64'(s_bvalid_o), 64'(1));
      chk("rr_ar_blocked", 64'(s_arready_o), 64'(0));
      @(negedge clk);
    end
    s_bready_i = 1'b1;
    #1;
    chk("rr_ar_blocked_hs", 64'(s_arready_o), 64'(0));
    @(posedge clk);
    #1;
    s_bready_i = 1'b0;
    chk("rr_b_drop", 64'(s_bvalid_o), 64'(0));
    chk("rr_ar_grant", 64'(s_arready_o), 64'(1));
    @(posedge clk);
    #1;
    s_arvalid_i = 1'b0;
    wb_serve(M_ACK, 0, n, s_adr, s_we, s_sel, s_dat);
    chk("rr_rd_we", 64'(s_we), 64'(0));
    resp_wait(1'b1, 0, 2'b00, mdl[2]);

    // Reset during a Wishbone read
    issue(1'b1, 32'h20, 32'h0, 4'h0);
    @(negedge clk);
    @(negedge clk);
    chk("mid_cyc_high", 64'(wb_cyc_o), 64'(1));
    rst_i = 1'b1;
    @(posedge clk);
    #1;
    chk("mid_rst_cyc", 64'(wb_cyc_o), 64'(0));
    chk("mid_rst_rvalid", 64'(s_rvalid_o), 64'(0));
    @(negedge clk);
    rst_i = 1'b0;
    do_txn(1'b1, 8, 32'h0, 4'h0, M_ACK, 1, 0);

    // Randomised traffic against the word model
    for (int t = 0; t < 24; t++) begin
      int r, mode;
      r = int'($urandom_range(0, 9));
      mode = (r < 7) ? M_ACK : (r < 8) ? M_ERR : (r < 9) ? M_BOTH : M_NONE;
      do_txn(1'($urandom_range(0, 1)), int'($urandom_range(0, 15)), $urandom,
             4'($urandom), mode, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
    end
    for (int i = 0; i < 16; i++)
      do_txn(1'b1, i, 32'h0, 4'h0, M_ACK, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
